// File: rtl/poly_tone_pkg.sv
`default_nettype none
// ============================================================================
// Module  : poly_tone_pkg
// Brief   : Shared FSM state type, rest constant and entry field helpers for
//           poly_tone_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package poly_tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam int REST = 0;

    // Entry layout is {duration, half_period[N-1], ..., half_period[0]}
    function automatic int hp_lsb(input int voice, input int div_w);
        return voice * div_w;
    endfunction

    function automatic int dur_lsb(input int n_voices, input int div_w);
        return n_voices * div_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_tone_if.sv
`default_nettype none
// ============================================================================
// Module  : poly_tone_if
// Brief   : Control, sequence-write and audio/status bundle of the sequencer.
// Rev     : 1.0  initial release
// ============================================================================
interface poly_tone_if #(
    parameter int N_VOICES  = 2,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 8,
    parameter int SEQ_DEPTH = 32,
    parameter int TICK_W    = 16
);
    logic [TICK_W-1:0]                 ticks_per_milli;
    logic                              start;
    logic                              stop;
    logic                              loop_en;
    logic                              seq_we;
    logic [$clog2(SEQ_DEPTH)-1:0]      seq_waddr;
    logic [DUR_W+N_VOICES*DIV_W-1:0]   seq_wdata;
    logic [N_VOICES-1:0]               voice_out;
    logic                              sound;
    logic [7:0]                        led;
    logic                              busy;

    modport master (
        output ticks_per_milli, start, stop, loop_en, seq_we, seq_waddr, seq_wdata,
        input  voice_out, sound, led, busy
    );

    modport slave (
        input  ticks_per_milli, start, stop, loop_en, seq_we, seq_waddr, seq_wdata,
        output voice_out, sound, led, busy
    );
endinterface
`default_nettype wire

// File: rtl/poly_tone_sequencer_voice.sv
`default_nettype none
// ============================================================================
// Module  : tone_voice
// Brief   : Square-wave voice: divider counter and toggle flop; half period
//           of REST holds the output low.
// Rev     : 1.0  initial release
// ============================================================================
module tone_voice
    import poly_tone_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic [DIV_W-1:0] i_half_period,
    output logic                  o_wave
);
    logic [DIV_W-1:0] r_cnt;
    logic             r_wave;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (i_clear || i_half_period == DIV_W'(REST)) begin
            r_cnt  <= '0;
            r_wave <= 1'b0;
        end else if (r_cnt == i_half_period - DIV_W'(1)) begin
            r_cnt  <= '0;
            r_wave <= ~r_wave;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
        end
    end

    assign o_wave = r_wave;
endmodule
`default_nettype wire

// File: rtl/poly_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : poly_tone_sequencer
// Brief   : Multi-voice square-wave step sequencer with writable step memory.
//           POLY_TONE_SIGMA_DELTA_EN selects a sigma-delta mix instead of XOR.
// Rev     : 1.0  initial release
// ============================================================================
module poly_tone_sequencer
    import poly_tone_pkg::*;
#(
    parameter int N_VOICES  = 2,
    parameter int DIV_W     = 16,
    parameter int DUR_W     = 8,
    parameter int SEQ_DEPTH = 32,
    parameter int TICK_W    = 16
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    poly_tone_if.slave bus
);
    localparam int             c_ENTRY_W = DUR_W + N_VOICES * DIV_W;
    localparam int             c_AW      = $clog2(SEQ_DEPTH);
    localparam int             c_DUR_LSB = dur_lsb(N_VOICES, DIV_W);
    localparam logic [c_AW-1:0] c_LAST   = c_AW'(SEQ_DEPTH - 1);

    logic [c_ENTRY_W-1:0] r_mem [SEQ_DEPTH];
    state_t               r_state, w_state_nxt;
    logic [c_AW-1:0]      r_step_idx, w_step_nxt;
    logic [TICK_W-1:0]    r_presc, w_tpm;
    logic [DUR_W-1:0]     r_dur, w_rd_dur;
    logic [DIV_W-1:0]     r_hp [N_VOICES];
    logic [c_ENTRY_W-1:0] w_rd;
    logic [N_VOICES-1:0]  w_voice;
    logic                 w_tick, w_step_end, w_clear, r_sound;
    logic [6:0]           w_idx7;

    always_ff @(posedge clk) begin
        if (bus.seq_we) begin
            r_mem[bus.seq_waddr] <= bus.seq_wdata;
        end
    end

    // Read data is consumed at the LOAD edge, so a same-cycle write is not seen
    assign w_rd       = r_mem[r_step_idx];
    assign w_rd_dur   = w_rd[c_DUR_LSB +: DUR_W];
    assign w_tpm      = (bus.ticks_per_milli == '0) ? TICK_W'(1) : bus.ticks_per_milli;
    assign w_tick     = (r_state == ST_PLAY) && (r_presc >= w_tpm - TICK_W'(1));
    assign w_step_end = w_tick && (r_dur == DUR_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step_idx;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_LOAD;
                    w_step_nxt  = '0;
                end
            end
            ST_LOAD: begin
                if (w_rd_dur == '0) begin
                    // End marker: a loop back to an empty step 0 would spin forever
                    w_state_nxt = (bus.loop_en && r_step_idx != '0) ? ST_LOAD : ST_IDLE;
                    w_step_nxt  = '0;
                end else begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_step_end) begin
                    if (r_step_idx != c_LAST) begin
                        w_state_nxt = ST_LOAD;
                        w_step_nxt  = r_step_idx + c_AW'(1);
                    end else begin
                        w_state_nxt = bus.loop_en ? ST_LOAD : ST_IDLE;
                        w_step_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = '0;
            end
        endcase
        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
            w_step_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_step_idx <= w_step_nxt;
        end
    end

    // Voices run only while staying in PLAY; leaving PLAY clears them on the same edge
    assign w_clear = (r_state != ST_PLAY) || (w_state_nxt != ST_PLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_dur   <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                r_hp[i] <= '0;
            end
        end else begin
            if (w_clear || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + TICK_W'(1);
            end
            if (r_state == ST_LOAD) begin
                r_dur <= w_rd_dur;
                for (int i = 0; i < N_VOICES; i++) begin
                    r_hp[i] <= w_rd[hp_lsb(i, DIV_W) +: DIV_W];
                end
            end else if (w_tick) begin
                r_dur <= r_dur - DUR_W'(1);
            end
        end
    end

    for (genvar g = 0; g < N_VOICES; g++) begin : g_voice
        tone_voice #(.DIV_W(DIV_W)) u_voice (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_clear       (w_clear),
            .i_half_period (r_hp[g]),
            .o_wave        (w_voice[g])
        );
    end

`ifdef POLY_TONE_SIGMA_DELTA_EN
    localparam int c_ACC_W = $clog2(N_VOICES) + 1;
    logic [c_ACC_W-1:0] r_acc, w_pop, w_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_VOICES; i++) begin
            w_pop = w_pop + c_ACC_W'(w_voice[i]);
        end
        w_sum = r_acc + w_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_sound <= 1'b0;
        end else if (w_state_nxt == ST_IDLE) begin
            r_acc   <= '0;
            r_sound <= 1'b0;
        end else if (w_sum >= c_ACC_W'(N_VOICES)) begin
            r_acc   <= w_sum - c_ACC_W'(N_VOICES);
            r_sound <= 1'b1;
        end else begin
            r_acc   <= w_sum;
            r_sound <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sound <= 1'b0;
        end else begin
            r_sound <= (w_state_nxt == ST_PLAY) ? ^w_voice : 1'b0;
        end
    end
`endif

    assign w_idx7        = 7'(r_step_idx);
    assign bus.voice_out = w_voice;
    assign bus.sound     = r_sound;
    assign bus.led       = {r_sound, w_idx7};
    assign bus.busy      = (r_state != ST_IDLE);
endmodule
`default_nettype wire
